// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
// The channel phase offset is only used when PWM_PHASE_STAGGER_EN is defined.
package pwm_pkg;

  localparam int unsigned CH_DEFAULT    = 32'd4;
  localparam int unsigned WIDTH_DEFAULT = 32'd8;

  // Start offset of channel idx within a period of 2^width cycles.
  function automatic int unsigned phase_offset(input int unsigned idx,
                                               input int unsigned ch_n,
                                               input int unsigned width);
    return idx * ((32'd1 << width) / ch_n);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active duty register, comparator and registered output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             aclk_i,
  input  logic             areset_i,
  input  logic             enable_i,
  input  logic             commit_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             pwm_o
);

  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] duty_d;
  logic             pwm_q;
  logic             pwm_d;

  // Duty only changes on a commit, which the top issues on a period boundary.
  always_comb begin
    duty_d = duty_q;
    if (commit_i) begin
      duty_d = duty_i;
    end else begin
      duty_d = duty_q;
    end
    pwm_d = enable_i && (cnt_i < duty_q);
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, duty-set handshake and CH channels.
// Define PWM_PHASE_STAGGER_EN to spread channel edges evenly across the period.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CH    = CH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                enable,
  input  logic [CH*WIDTH-1:0] duty_in,
  input  logic                duty_valid,
  output logic                duty_ready,
  output logic                period_start,
  output logic [CH-1:0]       pwm_out
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]    cnt_q;
  logic [WIDTH-1:0]    cnt_d;
  logic                pending_q;
  logic                pending_d;
  logic [CH*WIDTH-1:0] pend_duty_q;
  logic [CH*WIDTH-1:0] pend_duty_d;
  logic                period_start_q;
  logic                period_start_d;
  logic                transfer;
  logic                commit;

  assign duty_ready = !pending_q && !areset;
  assign transfer   = duty_valid && duty_ready;
  // Only a set that was already pending commits, so one taken on the last
  // count waits a full period; while disabled it commits at once.
  assign commit     = pending_q && (!enable || (cnt_q == CNT_MAX));

  always_comb begin
    cnt_d          = cnt_q;
    pending_d      = pending_q;
    pend_duty_d    = pend_duty_q;
    period_start_d = enable && (cnt_q == '0);

    if (enable) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = '0;
    end

    if (commit) begin
      pending_d = 1'b0;
    end else if (transfer) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    if (transfer) begin
      pend_duty_d = duty_in;
    end else begin
      pend_duty_d = pend_duty_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      pend_duty_q    <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      pend_duty_q    <= pend_duty_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_ch;
`ifdef PWM_PHASE_STAGGER_EN
    localparam logic [WIDTH-1:0] OFFSET = WIDTH'(phase_offset(g, CH, WIDTH));
    assign cnt_ch = cnt_q + OFFSET;
`else
    assign cnt_ch = cnt_q;
`endif

    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .aclk_i   (aclk),
      .areset_i (areset),
      .enable_i (enable),
      .commit_i (commit),
      .duty_i   (pend_duty_q[g*WIDTH +: WIDTH]),
      .cnt_i    (cnt_ch),
      .pwm_o    (pwm_out[g])
    );
  end

endmodule
